mem_access_unit: RTL
====================

# mem_access_unit

- Data-memory initiator for the MEM stage of the 5-stage RV64 scpu.
- Takes the load/store in EX/MEM, runs a req/ack transaction to data memory with lane alignment and sign extension, and stalls the pipeline until the access completes.
- Its load_data output feeds the MEM/WB register's data-in field.

## Interface
Parameters:
- DMEM_AW, 64, data-memory byte-address width
- TIMEOUT, 255, ack-wait cycles before abort (0 = never)

Ports:
- clk  in  1  pipeline clock; one clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  EX/MEM holds a live instruction
- mem_read  in  1  load
- mem_write  in  1  store
- mem_funct3  in  3  RV width/sign field
- mem_addr  in  DMEM_AW  effective address (ALU result)
- mem_wdata  in  64  store data (rs2)
- stall  out  1  holds PC, IF/ID, ID/EX, EX/MEM; MEM/WB takes a bubble
- load_data  out  64  aligned, extended load result
- fault  out  1  one-cycle pulse: misaligned, illegal funct3, read&write together, or timeout
- dmem_req  out  1  request
- dmem_we  out  1  write enable
- dmem_addr  out  DMEM_AW  doubleword address (low 3 bits zero)
- dmem_wdata  out  64  lane-shifted store data
- dmem_wstrb  out  8  byte strobes
- dmem_ack  in  1  completion; valid only while dmem_req high
- dmem_rdata  in  64  read data, valid with dmem_ack on reads

## Operation
- **Op present**: mem_valid & (mem_read | mem_write).
- **Legal funct3**:
  - loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
  - stores: 000–011
  - anything else is illegal.
- **Size**: 1/2/4/8 bytes from funct3[1:0].
- **Misaligned**: addr[2:0] not a multiple of size.
- **States**:
  - IDLE: on a legal op, latch all request fields into output regs, go to ACCESS. On an illegal op, go to FAULT. With no op, stay in IDLE.
  - ACCESS: dmem_req=1; dmem_* outputs held stable until ack; a wait counter increments.
    - On dmem_ack: capture the aligned rdata (loads) into load_data, or 0 (stores), drop dmem_req, go to DONE.
    - When the counter reaches TIMEOUT with no ack: drop dmem_req, set load_data=0, go to FAULT.
  - DONE: one cycle, then IDLE.
  - FAULT: fault=1 for one cycle, load_data=0, then IDLE.
- **Store alignment**:
  - dmem_wdata = mem_wdata << (8·addr[2:0]).
  - dmem_wstrb = ((1<<size)−1) << addr[2:0].
  - dmem_we=1.
- **Load alignment**:
  - r = dmem_rdata >> (8·addr[2:0]), truncated to size.
  - Sign-extended for funct3[2]=0, zero-extended for funct3[2]=1.
  - On loads dmem_wstrb=0 and dmem_we=0.
- **stall** = (IDLE & op present) | ACCESS. It is low in DONE and FAULT, so EX/MEM advances exactly once per op.
- **No re-issue**: the op still visible during DONE/FAULT is never re-issued, because the state returns to IDLE only after EX/MEM has advanced.

## Timing
- **Reset values**: state IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, load_data, fault all 0; wait counter 0. stall is forced 0 while rst=1.
- **Reset mid-ACCESS**: dmem_req drops the next cycle. A late ack arriving while not in ACCESS is ignored.
- **Fastest legal op**:
  - op first seen in cycle T → dmem_req high in T+1.
  - Ack in T+1 → DONE in T+2.
  - stall high in T and T+1 (two stall cycles); load_data valid in T+2 and held until the next capture.
- **Each extra wait cycle** adds one stall cycle.
- **Illegal op**: stall high in T, FAULT (fault=1, stall=0) in T+1, no dmem_req ever.
- **Timeout**: dmem_req high for exactly TIMEOUT cycles, then FAULT.
- **Back-to-back ops**: the next op is seen in IDLE at T+3 at the earliest.
- **Idle**: mem_valid=0 never leaves IDLE and keeps stall=0.

## Structure
- **Package scpu_mem_pkg**: funct3 constants (F3_B/H/W/D/BU/HU/WU), the state enum {IDLE, ACCESS, DONE, FAULT}, and a size-decode function.
- **Sub-module mem_lane_align**: combinational.
  - Store side: store shift and strobe generation.
  - Load side: load extract and extension.
  - Instantiated once and shared by both paths.
- **Top level**: owns the FSM, output regs and timeout counter.

## Test plan
- **LD, zero wait**: addr 0x1000, ack in the first ACCESS cycle, rdata 0x8877665544332211 → dmem_addr 0x1000, stall 2 cycles, load_data 0x8877665544332211.
- **LB vs LBU**: addr 0x1003, rdata 0x00000000F0000000 → LB gives 0xFFFFFFFFFFFFFFF0; LBU gives 0x00000000000000F0.
- **SH**: addr 0x2006, wdata 0xABCD → dmem_wdata 0xABCD000000000000, wstrb 0xC0, we=1; 3 wait cycles → stall 5 cycles.
- **Misaligned LW**: addr 0x3002 → no dmem_req, fault pulse in T+1, load_data 0, stall 1 cycle.
- **Timeout**: TIMEOUT=4, ack never arrives → dmem_req high 4 cycles, fault pulse, pipeline released.
- **Reset mid-ACCESS**: assert rst during ACCESS, then send an ack afterwards → all outputs 0 next cycle, state IDLE, the ack has no effect.

Source files
------------

// File: rtl/scpu_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory initiator:
// funct3 encodings, FSM states, and access-size decode.
package scpu_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} mau_state_t;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment: store shift/strobes and
// load extract with sign or zero extension.
module mem_lane_align
  import scpu_mem_pkg::*;
(
  input  logic [2:0]  i_off,
  input  logic [2:0]  i_f3,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_wdata,
  output logic [7:0]  o_wstrb,
  output logic [63:0] o_rdata
);

  logic [7:0]  w_mask;
  logic [63:0] w_sh;

  assign w_mask  = 8'((9'h1 << size_bytes(i_f3)) - 9'h1);
  assign o_wstrb = w_mask << i_off;
  assign o_wdata = i_wdata << {i_off, 3'b000};
  assign w_sh    = i_rdata >> {i_off, 3'b000};

  // funct3[2] selects zero extension (unsigned loads).
  always_comb begin
    o_rdata = w_sh;
    case (i_f3[1:0])
      2'b00:   o_rdata = i_f3[2] ? {56'b0, w_sh[7:0]}  : {{56{w_sh[7]}},  w_sh[7:0]};
      2'b01:   o_rdata = i_f3[2] ? {48'b0, w_sh[15:0]} : {{48{w_sh[15]}}, w_sh[15:0]};
      2'b10:   o_rdata = i_f3[2] ? {32'b0, w_sh[31:0]} : {{32{w_sh[31]}}, w_sh[31:0]};
      default: o_rdata = w_sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: issues one req/ack transaction per
// load/store, stalls the pipeline until it completes, aborts on timeout.
module mem_access_unit
  import scpu_mem_pkg::*;
#(
  parameter int DMEM_AW = 64,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_valid,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         mem_funct3,
  input  logic [DMEM_AW-1:0] mem_addr,
  input  logic [63:0]        mem_wdata,
  output logic               stall,
  output logic [63:0]        load_data,
  output logic               fault,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [63:0]        dmem_wdata,
  output logic [7:0]         dmem_wstrb,
  input  logic               dmem_ack,
  input  logic [63:0]        dmem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TL = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TMO_LAST = CW'(TL);

  mau_state_t r_state, w_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_off, r_f3;
  logic          r_req, r_we, r_fault;
  logic [DMEM_AW-1:0] r_addr;
  logic [63:0]   r_wdata, r_load;
  logic [7:0]    r_wstrb;

  logic          w_op, w_f3_ok, w_mis, w_legal, w_tmo, w_stall;
  logic [2:0]    w_off, w_f3;
  logic [63:0]   w_wsh, w_rext;
  logic [7:0]    w_strb;

  assign w_op    = mem_valid & (mem_read | mem_write);
  assign w_f3_ok = mem_read ? (mem_funct3 inside {F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU})
                            : (mem_funct3 inside {F3_B, F3_H, F3_W, F3_D});
  assign w_mis   = (mem_addr[2:0] & 3'(size_bytes(mem_funct3) - 4'd1)) != 3'b000;
  assign w_legal = w_f3_ok & ~w_mis & ~(mem_read & mem_write);
  assign w_tmo   = (TIMEOUT != 0) && (r_cnt == TMO_LAST);

  // Store path is used while issuing from IDLE; load path uses the latched request.
  assign w_off = (r_state == IDLE) ? mem_addr[2:0] : r_off;
  assign w_f3  = (r_state == IDLE) ? mem_funct3    : r_f3;

  mem_lane_align u_align (
    .i_off  (w_off),
    .i_f3   (w_f3),
    .i_wdata(mem_wdata),
    .i_rdata(dmem_rdata),
    .o_wdata(w_wsh),
    .o_wstrb(w_strb),
    .o_rdata(w_rext)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_stall = 1'b0;
    case (r_state)
      IDLE: if (w_op) begin
        w_stall = 1'b1;
        w_nxt   = w_legal ? ACCESS : FAULT;
      end
      ACCESS: begin
        w_stall = 1'b1;
        if (dmem_ack)   w_nxt = DONE;
        else if (w_tmo) w_nxt = FAULT;
      end
      default: w_nxt = IDLE;
    endcase
    if (rst) w_stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_load  <= '0;
      r_fault <= 1'b0;
      r_cnt   <= '0;
      r_off   <= '0;
      r_f3    <= '0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        IDLE: if (w_op) begin
          if (w_legal) begin
            r_req   <= 1'b1;
            r_we    <= mem_write;
            r_addr  <= {mem_addr[DMEM_AW-1:3], 3'b000};
            r_wdata <= mem_write ? w_wsh  : '0;
            r_wstrb <= mem_write ? w_strb : '0;
            r_off   <= mem_addr[2:0];
            r_f3    <= mem_funct3;
            r_cnt   <= '0;
          end else begin
            r_fault <= 1'b1;
            r_load  <= '0;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            r_req  <= 1'b0;
            r_load <= r_we ? 64'd0 : w_rext;
          end else if (w_tmo) begin
            r_req   <= 1'b0;
            r_load  <= '0;
            r_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall      = w_stall;
  assign load_data  = r_load;
  assign fault      = r_fault;
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_wstrb = r_wstrb;

endmodule
